// File: rtl/uart_stream_player.sv
// Snapshots a wide payload and plays it MSB-byte-first as 8N1/8N2 UART frames with optional gap.
// Latency: start sampled at edge N puts the start bit on tx_out from N+1; done_pulse one cycle after the last frame.
// No backpressure: start is a level request honoured only in IDLE; abort ends the run at the next frame boundary.
module uart_stream_player #(
  parameter int DATA_WIDTH         = 1072,
  parameter int UART_TICKS_PER_BIT = 9,
  parameter int STOP_BITS          = 1,
  parameter int GAP_BITS           = 0,
  parameter int PERIOD_TICKS       = 4096,
  localparam int MAX_BYTES         = DATA_WIDTH / 8,
  localparam int CW                = $clog2(MAX_BYTES + 1)
) (
  input  logic                  clk_in,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [CW-1:0]         num_bytes,
  input  logic                  start,
  input  logic                  repeat_en,
  input  logic                  abort,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  byte_pulse,
  output logic                  done_pulse,
  output logic [CW-1:0]         bytes_sent
);

  localparam int TW = $clog2(UART_TICKS_PER_BIT);
  localparam int PW = $clog2(PERIOD_TICKS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(UART_TICKS_PER_BIT - 1);
  localparam logic [TW-1:0] TICK_PEN  = TW'(UART_TICKS_PER_BIT - 2);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [3:0]    LAST_GAP  = 4'(GAP_BITS - 1);
  localparam logic [PW-1:0] WAIT_LAST = PW'(PERIOD_TICKS - 1);
  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_BYTES);
  localparam bit            HAS_GAP   = (GAP_BITS != 0);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;
  localparam logic [2:0] WAIT  = 3'd5;

  // Reject parameter sets the frame engine cannot represent.
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
    $error("uart_stream_player: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (UART_TICKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      GAP_BITS < 0 || GAP_BITS > 15 || PERIOD_TICKS < 1) begin : g_bad_params
    $error("uart_stream_player: timing parameter out of range");
  end

  logic [2:0]            state;
  logic [TW-1:0]         tick;
  logic [3:0]            bit_idx;
  logic [DATA_WIDTH-1:0] shadow;
  logic [CW-1:0]         run_cnt;
  logic                  abort_seen;
  logic [PW-1:0]         wait_cnt;

  logic          tick_end;
  logic          last_stop;
  logic          abort_now;
  logic          frame_end;
  logic          launch;
  logic          finish;
  logic [CW-1:0] launch_cnt;
  logic [7:0]    cur_byte;

  // Shadow is shifted left per frame, so the byte on the wire is always the top one.
  assign cur_byte   = shadow[DATA_WIDTH-1 -: 8];
  assign tick_end   = (tick == TICK_LAST);
  assign last_stop  = (bit_idx == LAST_STOP);
  assign abort_now  = abort_seen | abort;
  assign launch_cnt = (num_bytes > MAX_CNT) ? MAX_CNT : num_bytes;
  // A frame ends after its final stop bit, or after the final gap bit when a gap is configured.
  assign frame_end  = tick_end &&
                      ((state == STOP && last_stop && !HAS_GAP) ||
                       (state == GAP && bit_idx == LAST_GAP));
  assign launch     = (state == IDLE && start) ||
                      (state == WAIT && !abort_now && wait_cnt == WAIT_LAST);
  // A run completes normally either on an empty launch or after its last frame without abort.
  assign finish     = (launch && launch_cnt == '0) ||
                      (frame_end && !abort_now && bytes_sent == run_cnt);

  assign busy   = (state != IDLE);
  assign tx_out = (state == START) ? 1'b0 :
                  (state == DATA)  ? cur_byte[bit_idx[2:0]] : 1'b1;

  // Frame sequencer, run bookkeeping and handshake pulses.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      tick       <= '0;
      bit_idx    <= '0;
      shadow     <= '0;
      run_cnt    <= '0;
      abort_seen <= 1'b0;
      wait_cnt   <= '0;
      bytes_sent <= '0;
      byte_pulse <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      byte_pulse <= 1'b0;
      done_pulse <= 1'b0;
      if (busy && abort) abort_seen <= 1'b1;
      if (state != IDLE && state != WAIT) tick <= tick_end ? '0 : tick + 1'b1;

      case (state)
        START: if (tick_end) begin
          state   <= DATA;
          bit_idx <= '0;
        end
        DATA: if (tick_end) begin
          if (bit_idx == 4'd7) begin
            state   <= STOP;
            bit_idx <= '0;
          end else begin
            bit_idx <= bit_idx + 1'b1;
          end
        end
        STOP: if (tick_end) begin
          if (!last_stop) begin
            bit_idx <= bit_idx + 1'b1;
          end else if (HAS_GAP) begin
            state   <= GAP;
            bit_idx <= '0;
          end
        end
        GAP: if (tick_end && bit_idx != LAST_GAP) bit_idx <= bit_idx + 1'b1;
        WAIT: begin
          if (abort_now) state <= IDLE;
          else           wait_cnt <= wait_cnt + 1'b1;
        end
        default: ;
      endcase

      // Count the frame on the last cycle of its final stop bit.
      if (state == STOP && last_stop && tick == TICK_PEN) begin
        byte_pulse <= 1'b1;
        if (bytes_sent != run_cnt) bytes_sent <= bytes_sent + 1'b1;
      end

      if (frame_end) begin
        bit_idx <= '0;
        if (abort_now) begin
          state <= IDLE;
        end else if (bytes_sent != run_cnt) begin
          state  <= START;
          shadow <= shadow << 8;
        end
      end

      if (launch) begin
        shadow     <= data_in;
        run_cnt    <= launch_cnt;
        bytes_sent <= '0;
        abort_seen <= 1'b0;
        tick       <= '0;
        bit_idx    <= '0;
        if (launch_cnt != '0) state <= START;
      end

      // An empty launch from IDLE stays in IDLE; otherwise repeat_en picks WAIT.
      if (finish) begin
        done_pulse <= 1'b1;
        wait_cnt   <= '0;
        state      <= (repeat_en && state != IDLE) ? WAIT : IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_stream_player.sv
// Bench for uart_stream_player: random and directed runs against a frame-level reference model.
// Expected frames and done events are queued at launch; independent monitors decode tx_out and compare.
module tb_uart_stream_player;

  localparam int T   = 4;
  localparam int DW  = 32;
  localparam int SB  = 2;
  localparam int GB  = 2;
  localparam int PT  = 16;
  localparam int MAXB = DW / 8;
  localparam int CW  = $clog2(MAXB + 1);
  localparam int F   = (9 + SB + GB) * T;
  localparam int STOP_POS = (9 + SB) * T - 1;

  typedef struct { logic [7:0] b; int cnt; int cyc; } frm_t;
  typedef struct { int cyc; logic busy; } dn_t;

  logic          clk_in = 1'b0;
  logic          reset_n;
  logic [DW-1:0] data_in;
  logic [CW-1:0] num_bytes;
  logic          start, repeat_en, abort;
  logic          tx_out, busy, byte_pulse, done_pulse;
  logic [CW-1:0] bytes_sent;

  uart_stream_player #(
    .DATA_WIDTH(DW), .UART_TICKS_PER_BIT(T), .STOP_BITS(SB),
    .GAP_BITS(GB), .PERIOD_TICKS(PT)
  ) dut (
    .clk_in(clk_in), .reset_n(reset_n), .data_in(data_in), .num_bytes(num_bytes),
    .start(start), .repeat_en(repeat_en), .abort(abort), .tx_out(tx_out),
    .busy(busy), .byte_pulse(byte_pulse), .done_pulse(done_pulse), .bytes_sent(bytes_sent)
  );

  always #5 clk_in = ~clk_in;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  frm_t exp_q[$];
  dn_t  done_q[$];

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bad(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: event with nothing expected (cycle %0d)", nm, cyc);
  endtask

  // Reference model: a run of n bytes sends min(n, MAXB) frames, MSB byte first, back to back.
  task automatic expect_run(input logic [DW-1:0] d, input int n, input int k,
                            input logic busy_at_done, output int dcyc);
    int cnt;
    frm_t f;
    dn_t  e;
    cnt = (n > MAXB) ? MAXB : n;
    for (int j = 0; j < cnt; j++) begin
      f.b = d[DW-1-8*j -: 8];
      f.cnt = j + 1;
      f.cyc = k + j * F;
      exp_q.push_back(f);
    end
    dcyc = k + cnt * F;
    e.cyc = dcyc;
    e.busy = busy_at_done;
    done_q.push_back(e);
  endtask

  task automatic launch(input logic [DW-1:0] d, input int n, input logic rep);
    data_in = d;
    num_bytes = CW'(n);
    repeat_en = rep;
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk_in);
  endtask

  task automatic chk_drained(input string nm);
    chk({nm, "_frames_left"}, exp_q.size(), 0);
    chk({nm, "_done_left"}, done_q.size(), 0);
  endtask

  // UART line decoder: times each frame from its start bit and samples mid-bit.
  logic       act = 1'b0;
  logic       have = 1'b0;
  logic       pulse_ok;
  int         c0, pos, bitn;
  logic [7:0] rx;
  frm_t       cur;

  always @(negedge clk_in) begin
    pulse_ok = 1'b0;
    if (!reset_n) begin
      act = 1'b0;
    end else if (!act) begin
      if (tx_out === 1'b0) begin
        act = 1'b1;
        c0 = cyc;
        rx = '0;
        if (exp_q.size() == 0) begin
          have = 1'b0;
          bad("unexpected_frame");
        end else begin
          have = 1'b1;
          cur = exp_q.pop_front();
          chk("frame_start_cycle", c0, cur.cyc);
        end
      end
    end else begin
      pos = cyc - c0;
      if (pos % T == T / 2) begin
        bitn = pos / T;
        if (bitn == 0)      chk("start_bit", tx_out, 1'b0);
        else if (bitn <= 8) rx[bitn-1] = tx_out;
        else                chk("stop_gap_bit", tx_out, 1'b1);
        if (bitn == 8 && have) chk("rx_byte", rx, cur.b);
      end
      if (pos == STOP_POS) begin
        pulse_ok = 1'b1;
        if (have) chk("bytes_sent_at_pulse", bytes_sent, cur.cnt);
      end
      if (pos == F - 1) act = 1'b0;
    end
    if (reset_n) chk("byte_pulse_timing", byte_pulse, pulse_ok);
  end

  // Done monitor: every done_pulse must match a queued run completion.
  dn_t dn;
  always @(negedge clk_in) begin
    if (reset_n && done_pulse === 1'b1) begin
      if (done_q.size() == 0) begin
        bad("unexpected_done_pulse");
      end else begin
        dn = done_q.pop_front();
        chk("done_cycle", cyc, dn.cyc);
        chk("busy_at_done", busy, dn.busy);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2, dc, dc2, n;
    logic [DW-1:0] d, d2;
    data_in = '0; num_bytes = '0; start = 1'b0; repeat_en = 1'b0; abort = 1'b0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_tx_out", tx_out, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_byte_pulse", byte_pulse, 1'b0);
    chk("rst_done_pulse", done_pulse, 1'b0);
    chk("rst_bytes_sent", bytes_sent, 0);
    repeat (3) @(negedge clk_in);
    reset_n = 1'b1;
    @(negedge clk_in);

    // Two-byte run; a start and data change mid-run must be ignored.
    d = 32'h41424344;
    k = cyc + 1;
    expect_run(d, 2, k, 1'b0, dc);
    launch(d, 2, 1'b0);
    chk("busy_after_start", busy, 1'b1);
    wait_until(k + 20);
    data_in = 32'hDEADBEEF;
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    wait_until(dc + 2);
    chk("bytes_sent_n2", bytes_sent, 2);
    chk_drained("n2");

    // Empty run: done next cycle, line stays idle.
    k = cyc + 1;
    expect_run(32'h12345678, 0, k, 1'b0, dc);
    launch(32'h12345678, 0, 1'b0);
    wait_until(k + 3);
    chk("busy_after_n0", busy, 1'b0);
    chk_drained("n0");

    // Over-range count clamps; abort together with start in IDLE is ignored.
    d = 32'hA55A0FF0;
    k = cyc + 1;
    expect_run(d, 7, k, 1'b0, dc);
    abort = 1'b1;
    launch(d, 7, 1'b0);
    abort = 1'b0;
    wait_until(dc + 2);
    chk("bytes_sent_clamp", bytes_sent, MAXB);
    chk_drained("clamp");

    // Random one-shot runs.
    for (int r = 0; r < 6; r++) begin
      d = $urandom;
      n = $urandom_range(0, 7);
      k = cyc + 1;
      expect_run(d, n, k, 1'b0, dc);
      launch(d, n, 1'b0);
      wait_until(dc + 2);
      chk("bytes_sent_rand", bytes_sent, (n > MAXB) ? MAXB : n);
      chk_drained("rand");
      repeat ($urandom_range(1, 4)) @(negedge clk_in);
    end

    // Periodic mode: relaunch PT cycles after done with the payload current at relaunch.
    d = $urandom;
    d2 = ~d;
    k = cyc + 1;
    expect_run(d, 2, k, 1'b1, dc);
    launch(d, 2, 1'b1);
    wait_until(dc + 3);
    data_in = d2;
    k2 = dc + PT;
    expect_run(d2, 2, k2, 1'b0, dc2);
    wait_until(dc + 8);
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    wait_until(k2 + 5);
    repeat_en = 1'b0;
    wait_until(dc2 + 2);
    chk("busy_after_repeat", busy, 1'b0);
    chk_drained("repeat");

    // Abort in a data bit of byte 1 of 3: only that frame completes, no done.
    d = 32'h5AC3E100;
    k = cyc + 1;
    begin
      frm_t f;
      f.b = d[DW-1 -: 8];
      f.cnt = 1;
      f.cyc = k;
      exp_q.push_back(f);
    end
    launch(d, 3, 1'b0);
    wait_until(k + 2 * T + 1);
    abort = 1'b1;
    @(negedge clk_in);
    abort = 1'b0;
    wait_until(k + F - 1);
    chk("busy_last_abort_cycle", busy, 1'b1);
    @(negedge clk_in);
    chk("busy_after_abort", busy, 1'b0);
    wait_until(k + 3 * F);
    chk("bytes_sent_abort", bytes_sent, 1);
    chk_drained("abort");

    // Abort while waiting between periodic runs.
    d = $urandom;
    k = cyc + 1;
    expect_run(d, 1, k, 1'b1, dc);
    launch(d, 1, 1'b1);
    wait_until(dc + 5);
    chk("busy_in_wait", busy, 1'b1);
    abort = 1'b1;
    repeat_en = 1'b0;
    @(negedge clk_in);
    abort = 1'b0;
    chk("busy_after_wait_abort", busy, 1'b0);
    wait_until(dc + PT + F);
    chk_drained("wait_abort");

    // Asynchronous reset in the middle of a data bit.
    d = 32'h00FF00FF;
    k = cyc + 1;
    expect_run(d, 2, k, 1'b0, dc);
    launch(d, 2, 1'b0);
    wait_until(k + 10);
    chk("tx_mid_frame", tx_out, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_tx_out", tx_out, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_bytes_sent", bytes_sent, 0);
    chk("arst_done_pulse", done_pulse, 1'b0);
    exp_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk_in);
    reset_n = 1'b1;
    @(negedge clk_in);
    d = $urandom;
    k = cyc + 1;
    expect_run(d, 3, k, 1'b0, dc);
    launch(d, 3, 1'b0);
    wait_until(dc + 2);
    chk("bytes_sent_post_reset", bytes_sent, 3);
    chk_drained("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
